ex_wb_skid: RTL and testbench

Two-entry skid buffer between the execute stage and the writeback result mux. It captures the five writeback candidates (ALU result, load data, CSR read value, PC+4, immediate), the one-hot writeback select, destination register and write-enable from EXU under a valid/ready handshake. It presents them, registered and in order, to WBU, whose one-hot 5:1 mux consumes `out_sel` and `out_in0..out_in4` directly. It also flags illegal (non-one-hot) selects and counts downstream stall cycles.

---
 rtl/npc_pkg.sv | 23 ++
 rtl/ex_wb_skid_onehot_chk.sv | 9 +
 rtl/ex_wb_skid.sv | 106 ++++++++++
 tb/tb_ex_wb_skid.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared writeback definitions: select bit indices and the payload that
// travels from execute to the writeback result mux.
package npc_pkg;

    localparam int XLEN       = 32;
    localparam int WB_SEL_ALU = 0;
    localparam int WB_SEL_MEM = 1;
    localparam int WB_SEL_CSR = 2;
    localparam int WB_SEL_PC4 = 3;
    localparam int WB_SEL_IMM = 4;

    typedef struct packed {
        logic [XLEN-1:0] in0;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] in3;
        logic [XLEN-1:0] in4;
        logic [4:0]      sel;
        logic [4:0]      rd;
        logic            wen;
    } wb_payload_t;

endpackage

// File: rtl/ex_wb_skid_onehot_chk.sv
// Flags whether a 5-bit writeback select has exactly one bit set.
module onehot_chk (
    input  logic [4:0] sel,
    output logic       is_onehot
);

    assign is_onehot = ($countones(sel) == 1);

endmodule

// File: rtl/ex_wb_skid.sv
// Two-entry in-order skid buffer between EXU and the WBU result mux, with a
// sticky illegal-select flag and a downstream stall cycle counter.
module ex_wb_skid
    import npc_pkg::*;
#(
    parameter int WIDTH = XLEN  // payload struct is sized by XLEN; keep equal
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_in0,
    input  logic [WIDTH-1:0] in_in1,
    input  logic [WIDTH-1:0] in_in2,
    input  logic [WIDTH-1:0] in_in3,
    input  logic [WIDTH-1:0] in_in4,
    input  logic [4:0]       in_sel,
    input  logic [4:0]       in_rd,
    input  logic             in_wen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_in0,
    output logic [WIDTH-1:0] out_in1,
    output logic [WIDTH-1:0] out_in2,
    output logic [WIDTH-1:0] out_in3,
    output logic [WIDTH-1:0] out_in4,
    output logic [4:0]       out_sel,
    output logic [4:0]       out_rd,
    output logic             out_wen,
    output logic             sel_err,
    output logic [31:0]      stall_cnt
);

    wb_payload_t head_q, tail_q, in_pl;
    logic [1:0]  count_q;
    logic        sel_err_q;
    logic [31:0] stall_q;
    logic        push, pop, in_onehot;

    assign in_pl = '{in0: in_in0, in1: in_in1, in2: in_in2, in3: in_in3,
                     in4: in_in4, sel: in_sel, rd: in_rd, wen: in_wen};

    // Handshake decoded from registered count only: no out_ready -> in_ready path.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    onehot_chk u_chk (
        .sel       (in_sel),
        .is_onehot (in_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
            sel_err_q <= 1'b0;
            stall_q   <= 32'd0;
        end else begin
            if (push && !in_onehot)
                sel_err_q <= 1'b1;
            if (out_valid && !out_ready)
                stall_q <= stall_q + 32'd1;
            // Flush wins over a same-cycle push/pop; payload regs keep stale data.
            if (flush) begin
                count_q <= 2'd0;
            end else begin
                case (count_q)
                    2'd0: if (push) begin
                        head_q  <= in_pl;
                        count_q <= 2'd1;
                    end
                    2'd1: case ({push, pop})
                        2'b10: begin
                            tail_q  <= in_pl;
                            count_q <= 2'd2;
                        end
                        2'b01:   count_q <= 2'd0;
                        2'b11:   head_q  <= in_pl;
                        default: ;
                    endcase
                    2'd2: if (pop) begin
                        head_q  <= tail_q;
                        count_q <= 2'd1;
                    end
                    default: count_q <= 2'd0;
                endcase
            end
        end
    end

    assign out_in0   = head_q.in0;
    assign out_in1   = head_q.in1;
    assign out_in2   = head_q.in2;
    assign out_in3   = head_q.in3;
    assign out_in4   = head_q.in4;
    assign out_sel   = head_q.sel;
    assign out_rd    = head_q.rd;
    assign out_wen   = head_q.wen;
    assign sel_err   = sel_err_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ex_wb_skid.sv
// Randomized bench for ex_wb_skid against a queue-based FIFO reference model.
module tb_ex_wb_skid;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_in0, in_in1, in_in2, in_in3, in_in4;
    logic [31:0] out_in0, out_in1, out_in2, out_in3, out_in4;
    logic [4:0]  in_sel, in_rd, out_sel, out_rd;
    logic        in_wen, out_wen, sel_err;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    wb_payload_t mq[$];
    bit          m_err;
    logic [31:0] m_stall;

    ex_wb_skid #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_in0(in_in0), .in_in1(in_in1), .in_in2(in_in2), .in_in3(in_in3), .in_in4(in_in4),
        .in_sel(in_sel), .in_rd(in_rd), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_in0(out_in0), .out_in1(out_in1), .out_in2(out_in2), .out_in3(out_in3), .out_in4(out_in4),
        .out_sel(out_sel), .out_rd(out_rd), .out_wen(out_wen),
        .sel_err(sel_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic wb_payload_t cur_out();
        wb_payload_t g;
        g = '{in0: out_in0, in1: out_in1, in2: out_in2, in3: out_in3, in4: out_in4,
              sel: out_sel, rd: out_rd, wen: out_wen};
        return g;
    endfunction

    function automatic wb_payload_t rnd_pl();
        wb_payload_t p;
        p.in0 = $urandom; p.in1 = $urandom; p.in2 = $urandom;
        p.in3 = $urandom; p.in4 = $urandom;
        p.sel = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(5'b1 << $urandom_range(0, 4));
        p.rd  = 5'($urandom);
        p.wen = 1'($urandom);
        return p;
    endfunction

    task automatic check_all();
        chk("out_valid", out_valid, mq.size() != 0);
        chk("in_ready", in_ready, mq.size() < 2);
        chk("sel_err", sel_err, m_err);
        chk("stall_cnt", stall_cnt, m_stall);
        if (mq.size() != 0)
            chk("head", cur_out(), mq[0]);
    endtask

    // Called at a negedge: drive one cycle, advance the model, check after the edge.
    task automatic step(input bit v, input bit rdy, input bit fl, input bit rs, input wb_payload_t p);
        bit push, pop;
        rst_n = rs; flush = fl; in_valid = v; out_ready = rdy;
        in_in0 = p.in0; in_in1 = p.in1; in_in2 = p.in2; in_in3 = p.in3; in_in4 = p.in4;
        in_sel = p.sel; in_rd = p.rd; in_wen = p.wen;
        if (!rs) begin
            mq.delete();
            m_err   = 1'b0;
            m_stall = 32'd0;
        end else begin
            push = v && (mq.size() < 2);
            pop  = (mq.size() != 0) && rdy;
            if (mq.size() != 0 && !rdy) m_stall = m_stall + 32'd1;
            if (push && $countones(p.sel) != 1) m_err = 1'b1;
            if (fl) mq.delete();
            else begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(p);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        wb_payload_t p, z;
        z = '0;
        m_err = 1'b0; m_stall = 32'd0;
        @(negedge clk);
        step(0, 0, 0, 0, z);
        step(0, 0, 0, 0, z);
        chk("rst_sel", out_sel, 5'd0);
        chk("rst_wen", out_wen, 1'b0);
        chk("rst_rd", out_rd, 5'd0);
        chk("rst_data", {out_in0, out_in1, out_in2, out_in3, out_in4}, 160'd0);

        // single push, drains next cycle
        p = '0; p.in0 = 32'h11; p.sel = 5'b00001; p.rd = 5'd3; p.wen = 1'b1;
        step(1, 1, 0, 1, p);
        chk("single_in0", out_in0, 32'h11);
        chk("single_rd", out_rd, 5'd3);
        step(0, 1, 0, 1, z);
        chk("single_gone", out_valid, 1'b0);

        // stall with two entries, then release
        step(1, 0, 0, 1, rnd_pl());
        step(1, 0, 0, 1, rnd_pl());
        chk("full_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, rnd_pl());
        step(0, 1, 0, 1, z);
        chk("ready_after_pop", in_ready, 1'b1);
        step(0, 1, 0, 1, z);
        step(0, 1, 0, 1, z);

        // streaming 100 entries
        for (int i = 0; i < 100; i++) begin
            p = rnd_pl(); p.in1 = i; p.sel = 5'b00010;
            step(1, 1, 0, 1, p);
            chk("stream_in1", out_in1, 32'(i));
        end
        step(0, 1, 0, 1, z);

        // flush with a full buffer and a concurrent push
        step(1, 0, 0, 1, rnd_pl());
        step(1, 0, 0, 1, rnd_pl());
        step(1, 0, 1, 1, rnd_pl());
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        step(0, 1, 0, 1, z);

        // illegal selects
        p = rnd_pl(); p.sel = 5'b00011;
        step(1, 1, 0, 1, p);
        chk("sel_err_set", sel_err, 1'b1);
        chk("sel_pass", out_sel, 5'b00011);
        p = rnd_pl(); p.sel = 5'b00000;
        step(1, 1, 0, 1, p);
        chk("sel_zero_pass", out_sel, 5'b00000);
        step(0, 1, 0, 1, z);
        step(0, 1, 0, 0, z);
        chk("sel_err_clr", sel_err, 1'b0);

        // stall counter wrap
        step(1, 0, 0, 1, rnd_pl());
        force dut.stall_q = 32'hFFFF_FFFD;
        #1 release dut.stall_q;
        m_stall = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, z);
        chk("stall_wrapped", stall_cnt, 32'd1);
        step(0, 1, 0, 1, z);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) != 0, rnd_pl());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
